// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: operand width, FSM state
// encoding and the registered control word driven onto the datapath.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Moore control word held in registers for a given state.
  typedef struct packed {
    logic a_sel;
    logic b_sel;
    logic prod_sel;
    logic reg_en;
    logic shift_en;
    logic busy;
    logic done;
  } ctrl_t;

  // Control word that must be presented while the FSM sits in state s.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      LOAD: begin
        c.a_sel    = 1'b1;
        c.b_sel    = 1'b1;
        c.prod_sel = 1'b1;
        c.reg_en   = 1'b1;
        c.busy     = 1'b1;
      end
      RUN: begin
        c.reg_en   = 1'b1;
        c.shift_en = 1'b1;
        c.busy     = 1'b1;
      end
      DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier RUN phase. Cleared by LOAD, advanced
// once per executed iteration, never wraps on its own.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_incr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Control FSM for the 32-bit shift-add multiplier datapath. Sequences LOAD,
// WIDTH add/shift iterations (optionally cut short once B is zero) and a
// DONE state held until the requester acknowledges the product.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b0,
  parameter int CNT_W      = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             iAck,
  input  logic             iB_LSB,
  input  logic             iB_Zero,
  output logic             a_sel,
  output logic             b_sel,
  output logic             prod_sel,
  output logic             Reg_Enable,
  output logic             Shift_Enable,
  output logic             oAdd_Enable,
  output logic             oBusy,
  output logic             oDone,
  output logic [CNT_W-1:0] oCount
);

  state_t r_state;
  ctrl_t  r_ctrl;

  logic w_early;
  logic w_last;
  logic w_clear;
  logic w_incr;

  // Early exit: B is already zero, so this RUN cycle does no useful work.
  assign w_early = EARLY_EXIT && (r_state == RUN) && iB_Zero;

  // The final iteration and the early-exit cycle do not advance the count,
  // so it never overflows and holds its value through DONE.
  assign w_clear = (r_state == LOAD);
  assign w_incr  = (r_state == RUN) && !w_early && !w_last;

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk     (Clock),
    .rst_n   (Reset),
    .i_clear (w_clear),
    .i_incr  (w_incr),
    .o_count (oCount),
    .o_last  (w_last)
  );

  // State register plus the control word registered for the state being entered.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_ctrl  <= '0;
    end else begin
      // NOTE: branches that do not assign simply hold the registers; this is a
      // clocked block, so an incomplete case cannot infer a latch.
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state <= LOAD;
            r_ctrl  <= ctrl_for(LOAD);
          end
        end
        LOAD: begin
          r_state <= RUN;
          r_ctrl  <= ctrl_for(RUN);
        end
        RUN: begin
          if (w_early || w_last) begin
            r_state <= DONE;
            r_ctrl  <= ctrl_for(DONE);
          end
        end
        DONE: begin
          if (iAck) begin
            if (Start) begin
              r_state <= LOAD;
              r_ctrl  <= ctrl_for(LOAD);
            end else begin
              r_state <= IDLE;
              r_ctrl  <= ctrl_for(IDLE);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_ctrl  <= '0;
        end
      endcase
    end
  end

  assign a_sel        = r_ctrl.a_sel;
  assign b_sel        = r_ctrl.b_sel;
  assign prod_sel     = r_ctrl.prod_sel;
  assign Reg_Enable   = r_ctrl.reg_en   && !w_early;
  assign Shift_Enable = r_ctrl.shift_en && !w_early;
  assign oAdd_Enable  = (r_state == RUN) && iB_LSB && !w_early;
  assign oBusy        = r_ctrl.busy;
  assign oDone        = r_ctrl.done;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control with a behavioural shift-add datapath closing the
// loop. Built with EARLY_EXIT=1; operands whose B has its MSB set run the
// full 32 iterations, so both exit paths are exercised by one instance.
module tb_mult_control;
  import mult_pkg::*;

  localparam int W  = 32;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, ack;
  logic          b_lsb, b_zero;
  logic          a_sel, b_sel, prod_sel, reg_en, shift_en, add_en, busy, done;
  logic [CW-1:0] count;

  mult_control #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .Start        (start),
    .iAck         (ack),
    .iB_LSB       (b_lsb),
    .iB_Zero      (b_zero),
    .a_sel        (a_sel),
    .b_sel        (b_sel),
    .prod_sel     (prod_sel),
    .Reg_Enable   (reg_en),
    .Shift_Enable (shift_en),
    .oAdd_Enable  (add_en),
    .oBusy        (busy),
    .oDone        (done),
    .oCount       (count)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the DUT's controls.
  logic [31:0] op_a, op_b;
  logic [63:0] m_a, m_p;
  logic [31:0] m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_p <= '0;
    end else if (reg_en) begin
      m_a <= a_sel ? {32'b0, op_a} : (shift_en ? (m_a << 1) : m_a);
      m_b <= b_sel ? op_b : (shift_en ? (m_b >> 1) : m_b);
      m_p <= prod_sel ? 64'd0 : (add_en ? (m_p + m_a) : m_p);
    end
  end

  assign b_lsb  = m_b[0];
  assign b_zero = (m_b == 32'd0);

  // Scoreboard
  typedef struct {
    logic [63:0] prod;
    int          cnt;
    int          cyc;
    int          shifts;
    int          adds;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: shift-add multiply of a by b, stopping once B's remaining bits are zero.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   bl;
    bl = 0;
    for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
    e.prod   = {32'b0, a} * {32'b0, b};
    e.cnt    = (bl < W) ? bl : W - 1;
    e.cyc    = (bl < W) ? bl + 2 : W + 1;   // LOAD cycle to first DONE cycle
    e.shifts = bl;
    e.adds   = $countones(b);
    exp_q.push_back(e);
  endtask

  // Monitor: tracks each operation from its LOAD cycle to its first DONE cycle.
  bit   in_op = 0;
  int   m_cyc, m_sh, m_add;
  exp_t e_got;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_op = 0;
    end else if (a_sel && reg_en) begin
      in_op = 1; m_cyc = 0; m_sh = 0; m_add = 0;
    end else if (in_op) begin
      m_cyc++;
      if (shift_en) begin
        check("run_count", count, m_sh);
        m_sh++;
      end
      if (add_en) m_add++;
      if (done) begin
        in_op = 0;
        check("queue_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_got = exp_q.pop_front();
          check("product",    m_p,   e_got.prod);
          check("done_count", count, e_got.cnt);
          check("latency",    m_cyc, e_got.cyc);
          check("shifts",     m_sh,  e_got.shifts);
          check("adds",       m_add, e_got.adds);
          check("done_busy",  busy,  1);
        end
      end
    end
  end

  // Driver tasks (inputs change 1 time unit after the rising edge).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit do_push);
    op_a = a; op_b = b; start = 1'b1;
    if (do_push) push_exp(a, b);
    @(posedge clk); #1;
    start = 1'b0;
    check("load_ctrl", {a_sel, b_sel, prod_sel, reg_en, shift_en, busy, done}, 7'b1111010);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 45 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
      else start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    check("done_seen", seen, 1);
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      check("hold_done",  done,   1);
      check("hold_regen", reg_en, 0);
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("hold_done_end", done, 1);
  endtask

  task automatic ack_op(input bit b2b, input logic [31:0] a, input logic [31:0] b);
    ack = 1'b1;
    if (b2b) begin
      op_a = a; op_b = b; start = 1'b1;
      push_exp(a, b);
    end else begin
      start = 1'b0;
    end
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    if (b2b)
      check("b2b_load", {a_sel, b_sel, prod_sel, reg_en, shift_en, busy, done}, 7'b1111010);
    else
      check("idle_ctrl", {a_sel, b_sel, prod_sel, reg_en, shift_en, add_en, busy, done}, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit          b2b, seen;

    rst_n = 1'b0; start = 1'b0; ack = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk); #1;
    check("reset_ctrl",  {a_sel, b_sel, prod_sel, reg_en, shift_en, add_en, busy, done}, 8'h00);
    check("reset_count", count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: 13*11, then back-to-back early exit and full-length cases.
    start_op(32'd13, 32'd11, 1);
    wait_done(); hold(5); ack_op(1, 32'd7, 32'd3);
    wait_done(); hold(0); ack_op(1, 32'hDEAD_BEEF, 32'd0);
    wait_done(); hold(2); ack_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(); hold(1); ack_op(0, '0, '0);
    start_op($urandom, 32'h8000_0000 | $urandom, 1);

    // Random operations with random ack delay and random back-to-back restarts.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom | 32'h8000_0000;
        1:       b = $urandom >> $urandom_range(1, 31);
        2:       b = $urandom & 32'h0000_00FF;
        default: b = $urandom;
      endcase
      b2b = 1'($urandom_range(0, 1));
      wait_done(); hold($urandom_range(0, 3)); ack_op(b2b, a, b);
      if (!b2b) start_op(a, b, 1);
    end
    wait_done(); hold(1); ack_op(0, '0, '0);

    // Reset in the middle of RUN at iteration 10.
    start_op(32'h1234_5678, 32'h8000_0001, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (count == CW'(10) && shift_en) seen = 1;
    end
    check("reached_count10", seen, 1);
    rst_n = 1'b0; #1;
    check("midrun_reset_ctrl",  {a_sel, b_sel, prod_sel, reg_en, shift_en, add_en, busy, done}, 8'h00);
    check("midrun_reset_count", count, 0);
    @(posedge clk); #1;
    check("reset_held_done", done, 0);
    rst_n = 1'b1;
    start_op(32'd100, 32'd200, 1);
    wait_done(); hold(1); ack_op(0, '0, '0);

    repeat (3) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
